// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/latch/execute/memory control sequencer
//
// Purpose:
//   Steps each instruction through FETCH -> LATCH -> EXEC and, for LOAD/STOR,
//   through the memory phases. Drives the strobes consumed by the PC, IR,
//   register file write port, PSR flag register and BRAM, and counts retired
//   instructions.
//
// Ports:
//   clk       in   1   system clock, rising edge
//   reset     in   1   asynchronous, active-high; clears all state
//   run       in   1   1 = execute, 0 = stop at the next instruction boundary
//   instr     in  16   instruction register contents (sampled in EXEC)
//   pc_en     out  1   PC increment strobe, one cycle per retired instruction
//   ir_en     out  1   IR load strobe
//   addr_sel  out  1   BRAM address mux: 0 = PC, 1 = Raddr
//   mem_we    out  1   BRAM write enable (STOR)
//   wb_sel    out  1   write-back mux: 0 = ALU, 1 = BRAM read data
//   reg_we    out  1   register file write strobe
//   flags_en  out  1   PSR flag update strobe
//   state     out  3   current state encoding (debug)
//   icount    out 16   retired-instruction counter, wraps

module cpu_ctrl_fsm #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    output logic        pc_en,
    output logic        ir_en,
    output logic        addr_sel,
    output logic        mem_we,
    output logic        wb_sel,
    output logic        reg_we,
    output logic        flags_en,
    output logic [2:0]  state,
    output logic [15:0] icount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_MEMRD = 3'd4,
        S_MEMWB = 3'd5,
        S_MEMWR = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_CMP,
        C_NOP,
        C_LOAD,
        C_STOR,
        C_INV
    } cls_t;

    state_t      state_q, state_d;
    logic [15:0] icount_q, icount_d;
    cls_t        cls;

    logic [3:0]  op_hi;
    logic [3:0]  op_ext;
    logic [7:0]  op;

    // Register selects and immediates are the decoder's business; the
    // reset vector is consumed by the PC register itself.
    logic        unused_bits;
    assign unused_bits = ^{instr[11:8], instr[3:0], PC_RESET};

    assign op_hi  = instr[15:12];
    assign op_ext = instr[7:4];
    assign op     = {op_hi, op_ext};

    // Instruction class. The opcode map mirrors the decoder:
    //   0000_eeee register ALU ops (AND 1, OR 2, XOR 3, ADDCU 4, ADD 5,
    //             ADDU 6, ADDC 7, SUB 9, NOT F), CMP 8/B, NOP 0
    //   0001..0011, 0101..0111, 1001, 1010  immediate ALU ops
    //   0100_0000 LOAD, 0100_0100 STOR
    //   1000_0eee shifts (LSHI/RSHI/ALSHI/ARSHI 0-3, LSH/RSH/ALSH/ARSH 4-7)
    //   1011_xxxx, 1100_xxxx immediate compares
    always_comb begin
        cls = C_INV;
        if (op == 8'h40) begin
            cls = C_LOAD;
        end else if (op == 8'h44) begin
            cls = C_STOR;
        end else if (op == 8'h00) begin
            cls = C_NOP;
        end else if (op == 8'h0B || op == 8'h08 || op_hi == 4'hB || op_hi == 4'hC) begin
            cls = C_CMP;
        end else begin
            case (op_hi)
                4'h0: begin
                    if (op_ext inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h9, 4'hF}) begin
                        cls = C_ALU;
                    end
                end
                4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA: begin
                    cls = C_ALU;
                end
                4'h8: begin
                    if (!op_ext[3]) begin
                        cls = C_ALU;
                    end
                end
                default: begin
                    cls = C_INV;
                end
            endcase
        end
    end

    // Strobes are decoded from the current state rather than registered:
    // the IR only becomes valid on entry to EXEC, so the execute-phase
    // strobes cannot be computed a cycle early.
    always_comb begin
        state_d  = state_q;
        pc_en    = 1'b0;
        ir_en    = 1'b0;
        addr_sel = 1'b0;
        mem_we   = 1'b0;
        wb_sel   = 1'b0;
        reg_we   = 1'b0;
        flags_en = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                // BRAM read of PC issued here; data is ready during LATCH.
                addr_sel = 1'b0;
                state_d  = S_LATCH;
            end
            S_LATCH: begin
                ir_en   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                case (cls)
                    C_LOAD: begin
                        addr_sel = 1'b1;
                        state_d  = S_MEMRD;
                    end
                    C_STOR: begin
                        // The write is committed here so a reset during
                        // MEMWR never leaves a half-finished store.
                        addr_sel = 1'b1;
                        mem_we   = 1'b1;
                        state_d  = S_MEMWR;
                    end
                    C_ALU: begin
                        reg_we   = 1'b1;
                        flags_en = 1'b1;
                        pc_en    = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                    C_CMP: begin
                        flags_en = 1'b1;
                        pc_en    = 1'b1;
                        state_d  = run ? S_FETCH : S_IDLE;
                    end
                    default: begin
                        // NOP and invalid opcodes only retire.
                        pc_en   = 1'b1;
                        state_d = run ? S_FETCH : S_IDLE;
                    end
                endcase
            end
            S_MEMRD: begin
                addr_sel = 1'b1;
                state_d  = S_MEMWB;
            end
            S_MEMWB: begin
                wb_sel  = 1'b1;
                reg_we  = 1'b1;
                pc_en   = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            S_MEMWR: begin
                pc_en   = 1'b1;
                state_d = run ? S_FETCH : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        icount_d = icount_q;
        if (pc_en) begin
            icount_d = icount_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            icount_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            icount_q <= icount_d;
        end
    end

    assign state  = state_q;
    assign icount = icount_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - self-checking bench for cpu_ctrl_fsm

module tb_cpu_ctrl_fsm;

    logic        clk;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic        pc_en, ir_en, addr_sel, mem_we, wb_sel, reg_we, flags_en;
    logic [2:0]  state;
    logic [15:0] icount;

    cpu_ctrl_fsm #(.PC_RESET(16'h0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .instr    (instr),
        .pc_en    (pc_en),
        .ir_en    (ir_en),
        .addr_sel (addr_sel),
        .mem_we   (mem_we),
        .wb_sel   (wb_sel),
        .reg_we   (reg_we),
        .flags_en (flags_en),
        .state    (state),
        .icount   (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe vector order: {pc_en, ir_en, addr_sel, mem_we, wb_sel, reg_we, flags_en}
    localparam logic [6:0] PC = 7'b1000000;
    localparam logic [6:0] IR = 7'b0100000;
    localparam logic [6:0] AS = 7'b0010000;
    localparam logic [6:0] MW = 7'b0001000;
    localparam logic [6:0] WB = 7'b0000100;
    localparam logic [6:0] RW = 7'b0000010;
    localparam logic [6:0] FE = 7'b0000001;
    localparam logic [6:0] NO = 7'b0000000;

    localparam int K_ALU = 0, K_CMP = 1, K_NOP = 2, K_LOAD = 3, K_STOR = 4, K_INV = 5;

    typedef struct {
        logic        run;
        logic [15:0] instr;
        logic [2:0]  st;
        logic [6:0]  stb;
        logic [15:0] ic;
    } vec_t;

    vec_t tbl[$];
    int   nchecks = 0;
    int   nerrors = 0;

    function automatic logic [25:0] obs();
        return {state, pc_en, ir_en, addr_sel, mem_we, wb_sel, reg_we, flags_en, icount};
    endfunction

    task automatic chk(input string name, input logic [25:0] act, input logic [25:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [15:0] i, input logic [2:0] s,
                       input logic [6:0] b, input logic [15:0] c);
        vec_t v;
        v.run = r; v.instr = i; v.st = s; v.stb = b; v.ic = c;
        tbl.push_back(v);
    endtask

    // Instruction class from the opcode map.
    function automatic int cls_of(input logic [15:0] i);
        logic [3:0] hi;
        logic [3:0] ex;
        hi = i[15:12];
        ex = i[7:4];
        if (hi == 4'h4) return (ex == 4'h0) ? K_LOAD : (ex == 4'h4) ? K_STOR : K_INV;
        if (hi == 4'h0 && ex == 4'h0) return K_NOP;
        if ((hi == 4'h0 && (ex == 4'h8 || ex == 4'hB)) || hi == 4'hB || hi == 4'hC) return K_CMP;
        if (hi == 4'h0) return (ex == 4'h0 || ex == 4'hA || ex == 4'hC || ex == 4'hD || ex == 4'hE) ? K_INV : K_ALU;
        if (hi == 4'h8) return (ex < 4'h8) ? K_ALU : K_INV;
        if (hi == 4'hD || hi == 4'hE || hi == 4'hF) return K_INV;
        return K_ALU;
    endfunction

    function automatic int seq_len(input int k);
        return (k == K_LOAD) ? 5 : (k == K_STOR) ? 4 : 3;
    endfunction

    // Expected {state, strobes} for cycle 'pos' of an instruction of class k.
    function automatic logic [9:0] exp_of(input int k, input int pos);
        case (pos)
            0: return {3'd1, NO};
            1: return {3'd2, IR};
            2: case (k)
                   K_ALU:  return {3'd3, RW | FE | PC};
                   K_CMP:  return {3'd3, FE | PC};
                   K_LOAD: return {3'd3, AS};
                   K_STOR: return {3'd3, AS | MW};
                   default: return {3'd3, PC};
               endcase
            3: return (k == K_LOAD) ? {3'd4, AS} : {3'd6, PC};
            default: return {3'd5, WB | RW | PC};
        endcase
    endfunction

    function automatic logic [15:0] rand_instr();
        logic [3:0] a;
        logic [3:0] b;
        logic [31:0] r;
        a = 4'($urandom_range(0, 15));
        b = 4'($urandom_range(0, 15));
        r = $urandom;
        case ($urandom_range(0, 7))
            0: return {4'h0, a, 4'h0, b};
            1: return {4'h4, a, 4'h0, b};
            2: return {4'h4, a, 4'h4, b};
            3: return {4'h0, a, 4'hB, b};
            4: return {4'h5, a, b, a};
            default: return r[15:0];
        endcase
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        run   = 1'b0;
        instr = 16'h0000;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int   idle;
        int   pos;
        int   k;
        int   n;
        logic [15:0] m_ic;
        logic [9:0]  e;

        do_reset();
        #1;
        chk("reset_state", obs(), 26'h0);
        #(-0);

        // Directed program: ADDI, LOAD, STOR, CMP, invalid, stop, restart,
        // then a LOAD with run dropped during MEMRD.
        add(1, 16'h5103, 0, NO, 0);
        add(1, 16'h5103, 1, NO, 0);
        add(1, 16'h5103, 2, IR, 0);
        add(1, 16'h5103, 3, RW | FE | PC, 0);
        add(1, 16'h4203, 1, NO, 1);
        add(1, 16'h4203, 2, IR, 1);
        add(1, 16'h4203, 3, AS, 1);
        add(1, 16'h4203, 4, AS, 1);
        add(1, 16'h4203, 5, WB | RW | PC, 1);
        add(1, 16'h4243, 1, NO, 2);
        add(1, 16'h4243, 2, IR, 2);
        add(1, 16'h4243, 3, AS | MW, 2);
        add(1, 16'h4243, 6, PC, 2);
        add(1, 16'h01B2, 1, NO, 3);
        add(1, 16'h01B2, 2, IR, 3);
        add(1, 16'h01B2, 3, FE | PC, 3);
        add(1, 16'hF0F0, 1, NO, 4);
        add(1, 16'hF0F0, 2, IR, 4);
        add(0, 16'hF0F0, 3, PC, 4);
        add(0, 16'hF0F0, 0, NO, 5);
        add(0, 16'hF0F0, 0, NO, 5);
        add(1, 16'hF0F0, 0, NO, 5);
        add(1, 16'h4203, 1, NO, 5);
        add(1, 16'h4203, 2, IR, 5);
        add(1, 16'h4203, 3, AS, 5);
        add(0, 16'h4203, 4, AS, 5);
        add(0, 16'h4203, 5, WB | RW | PC, 5);
        add(0, 16'h4203, 0, NO, 6);
        add(0, 16'h4203, 0, NO, 6);
        add(1, 16'h4203, 0, NO, 6);
        add(1, 16'h4203, 1, NO, 6);

        foreach (tbl[i]) begin
            run   = tbl[i].run;
            instr = tbl[i].instr;
            #1;
            chk($sformatf("vec%0d", i), obs(), {tbl[i].st, tbl[i].stb, tbl[i].ic});
            @(posedge clk);
            #1;
        end

        // Asynchronous reset in the middle of an EXEC cycle.
        do_reset();
        run   = 1'b1;
        instr = 16'h5103;
        repeat (3) @(posedge clk);
        #1;
        chk("exec_before_reset", obs(), {3'd3, RW | FE | PC, 16'd0});
        #2 reset = 1'b1;
        #1;
        chk("async_reset", obs(), 26'h0);
        @(posedge clk);
        #1 reset = 1'b0;
        run = 1'b0;

        // Counter wrap: preset the counter while idle, then retire two NOPs.
        @(posedge clk);
        #1;
        force dut.icount_q = 16'hFFFE;
        #1;
        release dut.icount_q;
        #1;
        chk("icount_preset", {10'h0, icount}, {10'h0, 16'hFFFE});
        run   = 1'b1;
        instr = 16'h0000;
        n = 0;
        for (int c = 0; c < 20 && n < 2; c++) begin
            if (pc_en) begin
                n++;
                @(posedge clk);
                #1;
                chk($sformatf("wrap%0d", n), {10'h0, icount}, {10'h0, (n == 1) ? 16'hFFFF : 16'h0000});
            end else begin
                @(posedge clk);
                #1;
            end
        end
        chk("wrap_timeout", 26'(n), 26'd2);

        // Randomized run against a cycle-sequence reference model.
        do_reset();
        idle = 1;
        pos  = 0;
        m_ic = 16'h0000;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            run = ($urandom_range(0, 9) != 0);
            if (!idle && pos == 1) instr = rand_instr();
            #1;
            if (idle != 0) begin
                chk($sformatf("rnd%0d", cyc), obs(), {3'd0, NO, m_ic});
            end else begin
                k = cls_of(instr);
                e = exp_of(k, pos);
                chk($sformatf("rnd%0d", cyc), obs(), {e, m_ic});
            end
            if (reg_we && mem_we) chk("we_exclusive", 26'd1, 26'd0);
            if (idle != 0) begin
                if (run) begin
                    idle = 0;
                    pos  = 0;
                end
            end else if (pos >= 2 && pos == seq_len(k) - 1) begin
                m_ic = m_ic + 16'd1;
                if (run) pos = 0;
                else idle = 1;
            end else begin
                pos++;
            end
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
